tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-slot time-division demultiplexer: receiver end of the 4-to-1 selector path. A serial stream of one sample per slot, with slot 0 marked by `frame_sync`, is routed into four per-channel registers. A complete frame is presented as a parallel word `d` with a one-cycle `frame_valid` strobe. The block also tracks frame alignment and flags sync errors. It sits after the 4:1 selector/serialiser and feeds parallel consumers.

## Interface
- `WIDTH`, default 1, bits per slot sample.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `din` input WIDTH: slot sample.
- `din_valid` input 1: `din` and `frame_sync` are sampled only when this is high.
- `frame_sync` input 1: marks the slot-0 sample of a frame.
- `d` output 4*WIDTH: last complete frame; slot i maps to `d[i*WIDTH +: WIDTH]`.
- `frame_valid` output 1: one-cycle pulse when `d` updates.
- `ch_stb` output 4: one-hot; bit i pulses when slot i was accepted.
- `slot` output 2: next expected slot index.
- `locked` output 1: high in LOCKED.
- `sync_err` output 1: one-cycle pulse on an alignment fault.

## Operation
- Two states: HUNT and LOCKED.
- The shadow buffer `sh[0..3]` holds the frame being assembled. `d` is double-buffered and only changes on a complete frame.
- **HUNT:**
  - Samples with `din_valid=1, frame_sync=0` are discarded.
  - A sample with `din_valid=1, frame_sync=1` writes `sh[0]`, sets `slot`=1 and moves to LOCKED.
- **LOCKED, `din_valid=1`:**
  - `slot`=1..3 with `frame_sync=0`: write `sh[slot]`, then `slot`=`slot`+1 mod 4.
  - `slot`=3 accepted: `d`={`din`,`sh[2]`,`sh[1]`,`sh[0]`}, `frame_valid` pulses, `slot` wraps to 0.
  - `slot`=0 with `frame_sync=1`: write `sh[0]`, `slot`=1. This is the normal frame start.
  - `slot`=1..3 with `frame_sync=1` (early sync):
    - `sync_err` pulses and the partial frame is discarded.
    - The sample is taken as slot 0: write `sh[0]`, `slot`=1, stay LOCKED.
  - `slot`=0 with `frame_sync=0` (missing sync):
    - `sync_err` pulses and the sample is discarded.
    - Go to HUNT with `slot`=0.
- **`din_valid=0`:** no state change. Gaps of any length inside a frame are allowed.
- **`ch_stb[i]`:** pulses for every accepted write to `sh[i]`, including the resync write to slot 0. It does not pulse for discarded samples.
- **Reset values:** state HUNT, `slot`=0, `d`=0, `sh`=0, `frame_valid`=0, `ch_stb`=0, `locked`=0, `sync_err`=0.

## Timing
- All outputs are registered.
- An effect caused by a sample at rising edge N is visible after edge N and holds until edge N+1.
- Latency:
  - Slot-3 sample at edge N: `d` is valid and `frame_valid`=1 in cycle N+1.
  - Minimum frame time is 4 cycles. Back-to-back frames give `frame_valid` every 4th cycle with no lost samples.
- `locked` rises in the cycle after the first accepted sync.
- `locked` falls in the cycle after a missing-sync error; `sync_err` is asserted in that same cycle.
- `sync_err` and `frame_valid` are never high in the same cycle.
- Reset mid-frame: assertion clears everything immediately, without waiting for a clock. The first edge after `rst_n` rises sees HUNT.
- Throughput: one sample per cycle; the block never stalls the source.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream. Required: all outputs 0 asynchronously, `locked`=0, `slot`=0.
- **Clean frame** (WIDTH=1): slots 1,0,0,1 back-to-back, sync on the first. Required: `d`=4'b1001, `frame_valid` one cycle after the 4th sample, `ch_stb` sequence 0001, 0010, 0100, 1000.
- **Gapped plus back-to-back:** two frames with random `din_valid` gaps, then 3 frames contiguous. Required: `frame_valid` exactly once per frame, `d` matches each frame, `d` stable between pulses.
- **Early sync:** sync arrives at `slot`=2. Required: `sync_err` one cycle, `d` unchanged, `slot`=1, `locked`=1. The next 3 samples complete a correct new frame.
- **Missing sync:** 4th sample accepted, then the next sample arrives without sync. Required: `sync_err`, `locked`=0. Samples before the next sync are ignored; relock then works.
- **Pre-lock data:** 5 samples without sync from reset. Required: no `ch_stb`, no `frame_valid`, `d`=0.

Source files
------------

// File: rtl/tdm_demux4.sv
// Four-slot TDM receiver: routes a serial slot stream into a parallel frame word,
// tracking frame alignment via frame_sync and flagging alignment faults.
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic               frame_sync,
    output logic [4*WIDTH-1:0] d,
    output logic               frame_valid,
    output logic [3:0]         ch_stb,
    output logic [1:0]         slot,
    output logic               locked,
    output logic               sync_err
);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [1:0]         slot_q, slot_d;
    logic [WIDTH-1:0]   sh_q [4];
    logic [WIDTH-1:0]   sh_d [4];
    logic [4*WIDTH-1:0] d_q, d_d;
    logic               fv_q, fv_d;
    logic [3:0]         stb_q, stb_d;
    logic               err_q, err_d;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        sh_d    = sh_q;
        d_d     = d_q;
        fv_d    = 1'b0;
        stb_d   = 4'b0000;
        err_d   = 1'b0;

        if (din_valid) begin
            if (frame_sync) begin
                // Any sync restarts the frame at slot 0; mid-frame it also drops the partial frame.
                err_d   = (state_q == LOCKED) && (slot_q != 2'd0);
                sh_d[0] = din;
                slot_d  = 2'd1;
                stb_d   = 4'b0001;
                state_d = LOCKED;
            end else if (state_q == LOCKED) begin
                if (slot_q == 2'd0) begin
                    err_d   = 1'b1;
                    slot_d  = 2'd0;
                    state_d = HUNT;
                end else begin
                    sh_d[slot_q] = din;
                    stb_d        = 4'b0001 << slot_q;
                    slot_d       = slot_q + 2'd1;
                    if (slot_q == 2'd3) begin
                        d_d  = {din, sh_q[2], sh_q[1], sh_q[0]};
                        fv_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            slot_q  <= 2'd0;
            sh_q    <= '{default: '0};
            d_q     <= '0;
            fv_q    <= 1'b0;
            stb_q   <= 4'b0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            sh_q    <= sh_d;
            d_q     <= d_d;
            fv_q    <= fv_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
        end
    end

    assign d           = d_q;
    assign frame_valid = fv_q;
    assign ch_stb      = stb_q;
    assign slot        = slot_q;
    assign locked      = (state_q == LOCKED);
    assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed and randomized bench for tdm_demux4 against a queue-based frame model.
module tb_tdm_demux4;

    localparam int WIDTH = 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [WIDTH-1:0]   din;
    logic               din_valid;
    logic               frame_sync;
    logic [4*WIDTH-1:0] d;
    logic               frame_valid;
    logic [3:0]         ch_stb;
    logic [1:0]         slot;
    logic               locked;
    logic               sync_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the frame being assembled is simply a queue of accepted samples.
    logic [WIDTH-1:0]   frame_q[$];
    logic               m_locked;
    logic [4*WIDTH-1:0] m_d;
    logic               m_fv;
    logic               m_err;
    logic [3:0]         m_stb;

    tdm_demux4 #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .d           (d),
        .frame_valid (frame_valid),
        .ch_stb      (ch_stb),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        frame_q.delete();
        m_locked = 1'b0;
        m_d      = '0;
        m_fv     = 1'b0;
        m_err    = 1'b0;
        m_stb    = 4'b0000;
    endtask

    task automatic model_step(input logic [WIDTH-1:0] di, input logic v, input logic fs);
        m_fv  = 1'b0;
        m_err = 1'b0;
        m_stb = 4'b0000;
        if (v) begin
            if (fs) begin
                if (m_locked && frame_q.size() > 0) m_err = 1'b1;
                frame_q.delete();
                frame_q.push_back(di);
                m_stb    = 4'b0001;
                m_locked = 1'b1;
            end else if (m_locked) begin
                if (frame_q.size() == 0) begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    frame_q.push_back(di);
                    m_stb = 4'(1 << (frame_q.size() - 1));
                    if (frame_q.size() == 4) begin
                        m_d  = {frame_q[3], frame_q[2], frame_q[1], frame_q[0]};
                        m_fv = 1'b1;
                        frame_q.delete();
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".d"},           32'(d),           32'(m_d));
        check({ctx, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
        check({ctx, ".ch_stb"},      32'(ch_stb),      32'(m_stb));
        check({ctx, ".slot"},        32'(slot),        32'(frame_q.size()));
        check({ctx, ".locked"},      32'(locked),      32'(m_locked));
        check({ctx, ".sync_err"},    32'(sync_err),    32'(m_err));
        check({ctx, ".err_fv_excl"}, 32'(sync_err & frame_valid), 32'd0);
    endtask

    task automatic step(input string ctx, input logic [WIDTH-1:0] di, input logic v, input logic fs);
        din        = di;
        din_valid  = v;
        frame_sync = fs;
        @(posedge clk);
        model_step(di, v, fs);
        #1;
        check_all(ctx);
    endtask

    task automatic rand_gap(input string ctx, input int maxgap);
        int n;
        n = $urandom_range(0, maxgap);
        for (int g = 0; g < n; g++) step(ctx, WIDTH'($urandom), 1'b0, 1'($urandom));
    endtask

    task automatic send_frame(input string ctx, input int maxgap);
        step(ctx, WIDTH'($urandom), 1'b1, 1'b1);
        for (int s = 1; s < 4; s++) begin
            rand_gap(ctx, maxgap);
            step(ctx, WIDTH'($urandom), 1'b1, 1'b0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Pre-lock samples are all discarded.
        for (int i = 0; i < 5; i++) step("prelock", WIDTH'($urandom), 1'b1, 1'b0);
        check("prelock.d_zero", 32'(d), 32'd0);

        // Clean frame 1,0,0,1 with sync on the first sample.
        step("clean0", 1'b1, 1'b1, 1'b1);
        check("clean0.stb", 32'(ch_stb), 32'h1);
        step("clean1", 1'b0, 1'b1, 1'b0);
        check("clean1.stb", 32'(ch_stb), 32'h2);
        step("clean2", 1'b0, 1'b1, 1'b0);
        check("clean2.stb", 32'(ch_stb), 32'h4);
        step("clean3", 1'b1, 1'b1, 1'b0);
        check("clean3.stb", 32'(ch_stb), 32'h8);
        check("clean3.d",   32'(d), 32'h9);
        check("clean3.fv",  32'(frame_valid), 32'd1);
        step("clean_after", 1'b0, 1'b0, 1'b0);
        check("clean_after.fv", 32'(frame_valid), 32'd0);

        // Two gapped frames, then three contiguous frames.
        for (int f = 0; f < 2; f++) send_frame("gapped", 3);
        for (int f = 0; f < 3; f++) send_frame("b2b", 0);

        // Early sync at slot 2.
        step("early0", WIDTH'($urandom), 1'b1, 1'b1);
        step("early1", WIDTH'($urandom), 1'b1, 1'b0);
        check("early1.slot", 32'(slot), 32'd2);
        step("early_sync", WIDTH'($urandom), 1'b1, 1'b1);
        check("early_sync.err",    32'(sync_err), 32'd1);
        check("early_sync.slot",   32'(slot), 32'd1);
        check("early_sync.locked", 32'(locked), 32'd1);
        for (int s = 1; s < 4; s++) step("early_done", WIDTH'($urandom), 1'b1, 1'b0);
        check("early_done.fv", 32'(frame_valid), 32'd1);

        // Missing sync after a completed frame.
        send_frame("miss_pre", 0);
        step("miss", WIDTH'($urandom), 1'b1, 1'b0);
        check("miss.err",    32'(sync_err), 32'd1);
        check("miss.locked", 32'(locked), 32'd0);
        for (int i = 0; i < 3; i++) step("miss_ignored", WIDTH'($urandom), 1'b1, 1'b0);
        send_frame("relock", 1);
        check("relock.fv", 32'(frame_valid), 32'd1);

        // Randomized stream with occasional syncs and gaps.
        for (int i = 0; i < 400; i++)
            step("random", WIDTH'($urandom), 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0));

        // Asynchronous reset mid-frame.
        step("midrst0", WIDTH'($urandom), 1'b1, 1'b1);
        step("midrst1", WIDTH'($urandom), 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_hunt", WIDTH'($urandom), 1'b1, 1'b0);
        check("post_rst_hunt.locked", 32'(locked), 32'd0);
        send_frame("post_rst", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
